// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared constants and helpers for the radix-4 Booth multiplier:
//                FSM state encoding, Booth digit encoding, triplet recoding
//                and iteration count selection.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Booth digit encoding: bit 2 is the sign, bits 1:0 the magnitude
    localparam logic [2:0] c_DIG_ZERO = 3'b000;
    localparam logic [2:0] c_DIG_P1   = 3'b001;
    localparam logic [2:0] c_DIG_P2   = 3'b010;
    localparam logic [2:0] c_DIG_M1   = 3'b101;
    localparam logic [2:0] c_DIG_M2   = 3'b110;

    // Map a {y[2i+1], y[2i], y[2i-1]} triplet onto its radix-4 digit
    function automatic logic [2:0] booth_digit(input logic [2:0] triplet);
        logic [2:0] dig;
        case (triplet)
            3'b001, 3'b010: dig = c_DIG_P1;
            3'b011:         dig = c_DIG_P2;
            3'b100:         dig = c_DIG_M2;
            3'b101, 3'b110: dig = c_DIG_M1;
            default:        dig = c_DIG_ZERO;
        endcase
        return dig;
    endfunction

    // Unsigned operands need one extra step so the zero-extension bits are
    // recoded; otherwise a set MSB would be read as a negative weight.
    function automatic int unsigned iter_count(input int unsigned width,
                                               input logic        signed_mode);
        return signed_mode ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_r4_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r4_recoder
//  Description : Combinational radix-4 Booth recoder. Turns a multiplier
//                triplet and the extended multiplicand into a partial product
//                plus a negate carry-in (negative digits are one's complement
//                here; the carry completes the two's complement downstream).
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int E_WIDTH = 8
) (
    input  logic [2:0]         i_triplet,
    input  logic [E_WIDTH-1:0] i_mcand,
    output logic [E_WIDTH:0]   o_pp,
    output logic               o_neg
);

    logic [2:0]       w_digit;
    logic [E_WIDTH:0] w_x1;
    logic [E_WIDTH:0] w_x2;

    assign w_digit = booth_digit(i_triplet);
    assign w_x1    = {i_mcand[E_WIDTH-1], i_mcand};
    assign w_x2    = {i_mcand, 1'b0};

    // Select the digit multiple; negative digits invert and request a carry
    always_comb begin
        o_pp  = '0;
        o_neg = 1'b0;
        case (w_digit)
            c_DIG_P1: o_pp = w_x1;
            c_DIG_P2: o_pp = w_x2;
            c_DIG_M1: begin
                o_pp  = ~w_x1;
                o_neg = 1'b1;
            end
            c_DIG_M2: begin
                o_pp  = ~w_x2;
                o_neg = 1'b1;
            end
            default: begin
                o_pp  = '0;
                o_neg = 1'b0;
            end
        endcase
    end

endmodule : booth_r4_recoder
`default_nettype wire

// File: rtl/booth_multiplier_r4.sv
`default_nettype none
// ============================================================================
//  Module      : booth_multiplier_r4
//  Description : Iterative radix-4 Booth multiplier with start/busy/done
//                handshake and per-operation signed/unsigned mode. Retires
//                two multiplier bits per cycle into a 2*(WIDTH+2) accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier_r4 #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import booth_pkg::*;

    localparam int c_E     = WIDTH + 2;
    localparam int c_ACC_W = 2 * c_E;
    localparam int c_CNT_W = $clog2(WIDTH / 2 + 2);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_E-1:0]       r_xe;
    logic [c_E:0]         r_ysh;
    logic                 r_signed;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_ACC_W-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_done;

    logic [c_E-1:0]       w_xe;
    logic [c_E-1:0]       w_ye;
    logic [c_E:0]         w_pp;
    logic                 w_neg;
    logic [c_ACC_W-1:0]   w_addend;
    logic [c_ACC_W-1:0]   w_acc_next;
    logic                 w_last;
    logic                 w_accept;

    // Operands widened by two bits: sign copies in signed mode, zeros otherwise
    assign w_xe = {{2{signed_mode & x[WIDTH-1]}}, x};
    assign w_ye = {{2{signed_mode & y[WIDTH-1]}}, y};

    assign w_accept = (r_state == c_ST_IDLE) && start;
    assign w_last   = (r_cnt == c_CNT_W'(iter_count(WIDTH, r_signed) - 1));

    // Low three bits of the shifting multiplier always hold the current triplet
    booth_r4_recoder #(
        .E_WIDTH (c_E)
    ) u_recoder (
        .i_triplet (r_ysh[2:0]),
        .i_mcand   (r_xe),
        .o_pp      (w_pp),
        .o_neg     (w_neg)
    );

    // Sign-extend, fold in the negate carry, then weight by 4^step
    assign w_addend   = ({{(c_ACC_W - c_E - 1){w_pp[c_E]}}, w_pp} + c_ACC_W'(w_neg))
                        << {r_cnt, 1'b1 ^ 1'b1};
    assign w_acc_next = r_acc + w_addend;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after last step, DONE -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (start)  w_next_state = c_ST_RUN;
            c_ST_RUN:  if (w_last) w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, accumulate one digit per RUN cycle,
    // publish the product together with the done pulse on the final step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_xe      <= '0;
            r_ysh     <= '0;
            r_signed  <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == c_ST_RUN) && w_last;
            if (w_accept) begin
                r_xe     <= w_xe;
                r_ysh    <= {w_ye, 1'b0};
                r_signed <= signed_mode;
                r_cnt    <= '0;
                r_acc    <= '0;
            end else if (r_state == c_ST_RUN) begin
                r_acc <= w_acc_next;
                r_ysh <= r_ysh >> 2;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_product <= w_acc_next[2*WIDTH-1:0];
                end
            end
        end
    end

    assign busy    = (r_state != c_ST_IDLE);
    assign done    = r_done;
    assign product = r_product;

endmodule : booth_multiplier_r4
`default_nettype wire

// File: tb/tb_booth_multiplier_r4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_multiplier_r4
//  Description : Self-checking bench for booth_multiplier_r4. Directed vector
//                table at WIDTH=6, hand-written handshake sequences, and a
//                WIDTH=8 sweep against an integer reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier_r4;

    logic        clk = 1'b0;
    logic        reset;

    logic        start6, sm6;
    logic [5:0]  x6, y6;
    logic        busy6, done6;
    logic [11:0] prod6;

    logic        start8, sm8;
    logic [7:0]  x8, y8;
    logic        busy8, done8;
    logic [15:0] prod8;

    int n_cmp = 0;
    int n_bad = 0;
    int dones6 = 0;

    always #5 clk = ~clk;

    booth_multiplier_r4 #(.WIDTH(6)) dut6 (
        .clk (clk), .reset (reset), .start (start6), .signed_mode (sm6),
        .x (x6), .y (y6), .busy (busy6), .done (done6), .product (prod6)
    );

    booth_multiplier_r4 #(.WIDTH(8)) dut8 (
        .clk (clk), .reset (reset), .start (start8), .signed_mode (sm8),
        .x (x8), .y (y8), .busy (busy8), .done (done8), .product (prod8)
    );

    // Count done pulses of the WIDTH=6 instance, sampled mid-cycle
    always @(negedge clk) begin
        if (done6) dones6 <= dones6 + 1;
    end

    typedef struct {
        logic        sm;
        logic [5:0]  x;
        logic [5:0]  y;
        logic [11:0] exp_p;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle6();
        for (int k = 0; k < 30 && busy6; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Issue one WIDTH=6 operation; return product, latency and busy-cycle count
    task automatic run6(input logic sm, input logic [5:0] xa, input logic [5:0] ya,
                        output logic [11:0] p, output int lat, output int bc);
        wait_idle6();
        @(negedge clk);
        start6 = 1'b1; sm6 = sm; x6 = xa; y6 = ya;
        @(posedge clk); #1;
        start6 = 1'b0; sm6 = ~sm; x6 = ~xa; y6 = ~ya;
        lat = 1;
        bc  = busy6 ? 1 : 0;
        while (!done6 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy6) bc++;
        end
        p = prod6;
    endtask

    task automatic run8(input logic sm, input logic [7:0] xa, input logic [7:0] ya,
                        output logic [15:0] p, output int lat);
        for (int k = 0; k < 30 && busy8; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; x8 = xa; y8 = ya;
        @(posedge clk); #1;
        start8 = 1'b0; x8 = ~xa; y8 = ~ya;
        lat = 1;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        p = prod8;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] p;
        logic [15:0] p8;
        logic [15:0] e8;
        int lat, bc, d0, k;

        //        sm    x      y      product  latency
        vecs[0] = '{1'b1, 6'd7,  6'd2,  12'h00E, 4};   //  7 * 2
        vecs[1] = '{1'b1, 6'h20, 6'h20, 12'h400, 4};   // -32 * -32
        vecs[2] = '{1'b1, 6'd7,  6'h39, 12'hFCF, 4};   //  7 * -7
        vecs[3] = '{1'b0, 6'h3F, 6'h3F, 12'hF81, 5};   //  63 * 63
        vecs[4] = '{1'b1, 6'h3F, 6'h3F, 12'h001, 4};   // -1 * -1
        vecs[5] = '{1'b0, 6'd7,  6'd2,  12'h00E, 5};   //  7 * 2 unsigned
        vecs[6] = '{1'b0, 6'h20, 6'h20, 12'h400, 5};   //  32 * 32
        vecs[7] = '{1'b1, 6'h1F, 6'h20, 12'hC20, 4};   //  31 * -32
        vecs[8] = '{1'b0, 6'h20, 6'h3F, 12'h7E0, 5};   //  32 * 63

        reset = 1'b1;
        start6 = 1'b0; sm6 = 1'b0; x6 = '0; y6 = '0;
        start8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy6", busy6, 0);
        check("reset done6", done6, 0);
        check("reset product6", prod6, 0);
        check("reset busy8", busy8, 0);
        check("reset product8", prod8, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run6(vecs[i].sm, vecs[i].x, vecs[i].y, p, lat, bc);
            check($sformatf("vec%0d product", i), p, vecs[i].exp_p);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d busy cycles", i), bc, vecs[i].exp_lat);
        end

        // done is a one-cycle pulse and busy drops right after it
        @(posedge clk); #1;
        check("done pulse width", done6, 0);
        check("busy after done", busy6, 0);
        check("product holds", prod6, 12'h7E0);

        // Start while busy is ignored
        wait_idle6();
        d0 = dones6;
        @(negedge clk);
        start6 = 1'b1; sm6 = 1'b1; x6 = 6'd7; y6 = 6'd7;
        @(posedge clk); #1;
        start6 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        start6 = 1'b1; x6 = 6'd1; y6 = 6'd1;
        @(posedge clk); #1;
        start6 = 1'b0;
        k = 0;
        while (!done6 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("busy-start product", prod6, 12'h031);
        repeat (10) @(posedge clk);
        #1;
        check("busy-start done count", dones6 - d0, 1);
        check("busy-start idle", busy6, 0);

        // Reset mid-operation
        d0 = dones6;
        @(negedge clk);
        start6 = 1'b1; sm6 = 1'b1; x6 = 6'd7; y6 = 6'd7;
        @(posedge clk); #1;
        start6 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset busy", busy6, 0);
        check("midreset done", done6, 0);
        check("midreset product", prod6, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midreset no done", dones6 - d0, 0);
        run6(1'b1, 6'd3, 6'd5, p, lat, bc);
        check("after reset product", p, 12'h00F);

        // Back-to-back with start held high
        wait_idle6();
        @(negedge clk);
        start6 = 1'b1; sm6 = 1'b1; x6 = 6'd7; y6 = 6'd2;
        @(posedge clk); #1;
        @(negedge clk);
        x6 = 6'd3;
        k = 1;
        while (!done6 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b first latency", k, 4);
        check("b2b first product", prod6, 12'h00E);
        @(posedge clk); #1;
        check("b2b idle gap", busy6, 0);
        @(posedge clk); #1;
        check("b2b second accepted", busy6, 1);
        k = 1;
        while (!done6 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b second latency", k, 4);
        check("b2b second product", prod6, 12'h006);
        @(negedge clk);
        start6 = 1'b0;

        // WIDTH=8 sweep against integer reference, corners first
        for (int i = 0; i < 32; i++) begin
            logic [7:0] xa, ya;
            logic       sm;
            int         a, b;
            sm = (i % 2 == 0);
            if (i < 2)      begin xa = 8'h80; ya = 8'h80; end
            else if (i < 4) begin xa = 8'hFF; ya = 8'hFF; end
            else if (i < 6) begin xa = 8'h7F; ya = 8'h80; end
            else begin
                xa = 8'($urandom);
                ya = 8'($urandom);
            end
            if (sm) begin
                a = int'($signed(xa));
                b = int'($signed(ya));
            end else begin
                a = int'(xa);
                b = int'(ya);
            end
            e8 = 16'(a * b);
            run8(sm, xa, ya, p8, lat);
            check($sformatf("w8 %0d product x=%0h y=%0h s=%0d", i, xa, ya, sm), p8, e8);
            check($sformatf("w8 %0d latency", i), lat, sm ? 5 : 6);
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_booth_multiplier_r4
`default_nettype wire
